// File: rtl/bus_arb_pkg.sv
// Shared types and sizing helpers for the tristate bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    TURN
  } state_e;

  // Width of a counter that must reach max_val inclusive.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after ptr, wrapping mod N.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [PW-1:0] idx
);

  int unsigned pos;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    valid = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!valid && req[PW'(pos)]) begin
        valid = 1'b1;
        idx   = PW'(pos);
      end
    end
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner selection with hold limit and guaranteed dead cycles for a shared tristate bus.
module tristate_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int N          = 4,
  parameter int W          = 4,
  parameter int MAX_HOLD   = 4,
  parameter int TURNAROUND = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] data_in,
  output logic [N-1:0]   grant,
  output logic           bus_en,
  output logic [W-1:0]   bus_a
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = cnt_w(MAX_HOLD);
  localparam int TW = cnt_w(TURNAROUND);

  state_e        state_q;
  logic [N-1:0]  grant_q;
  logic          bus_en_q;
  logic [PW-1:0] owner_q;
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [CW-1:0] hold_q;
  logic [TW-1:0] turn_q;

  logic          pick_valid;
  logic [PW-1:0] pick_idx;
  logic [N-1:0]  pick_onehot;

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign pick_onehot = {{(N-1){1'b0}}, 1'b1} << pick_idx;
  assign ptr_d       = (owner_q == PW'(N - 1)) ? '0 : owner_q + PW'(1);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values of its peers.
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      bus_en_q <= 1'b0;
      owner_q  <= '0;
      ptr_q    <= '0;
      hold_q   <= '0;
      turn_q   <= '0;
    end else begin
      case (state_q)
        IDLE, TURN: begin
          if (state_q == TURN && turn_q < TW'(TURNAROUND)) begin
            turn_q <= turn_q + TW'(1);
          end else if (pick_valid) begin
            state_q  <= OWN;
            grant_q  <= pick_onehot;
            bus_en_q <= 1'b1;
            owner_q  <= pick_idx;
            hold_q   <= CW'(1);
          end else begin
            state_q <= IDLE;
          end
        end
        OWN: begin
          if (req[owner_q] && hold_q < CW'(MAX_HOLD)) begin
            hold_q <= hold_q + CW'(1);
          end else begin
            // Pointer moves only on release, so a forced-off owner waits its turn.
            state_q  <= TURN;
            grant_q  <= '0;
            bus_en_q <= 1'b0;
            ptr_q    <= ptr_d;
            turn_q   <= TW'(1);
          end
        end
        default: begin
          state_q  <= IDLE;
          grant_q  <= '0;
          bus_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign grant  = grant_q;
  assign bus_en = bus_en_q;

  always_comb begin
    bus_a = '0;
    if (bus_en_q) bus_a = data_in[int'(owner_q)*W +: W];
  end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Self-checking bench: directed vector table, data-tracking sequence and randomized traffic vs. a reference model.
module tb_tristate_bus_arbiter;

  localparam int N          = 4;
  localparam int W          = 4;
  localparam int MAX_HOLD   = 4;
  localparam int TURNAROUND = 1;
  localparam int NVEC       = 33;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   grant;
  logic           bus_en;
  logic [W-1:0]   bus_a;

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the bus and for how long, plus remaining dead cycles.
  int m_owner = -1;
  int m_held  = 0;
  int m_dead  = 0;
  int m_ptr   = 0;
  logic m_rst_at_edge = 1'b0;

  // Invariant tracking across cycles.
  logic [N-1:0] prev_g = '0;
  int zero_run = 0;
  logic seen_owner = 1'b0;

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] g;
    logic [W-1:0] a;
  } vec_t;

  vec_t tbl[NVEC];

  tristate_bus_arbiter #(
    .N(N), .W(W), .MAX_HOLD(MAX_HOLD), .TURNAROUND(TURNAROUND)
  ) dut (
    .clk     (clk),
    .reset   (rst),
    .req     (req),
    .data_in (data),
    .grant   (grant),
    .bus_en  (bus_en),
    .bus_a   (bus_a)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    m_rst_at_edge = rst;
    if (rst) begin
      m_owner = -1; m_held = 0; m_dead = 0; m_ptr = 0;
    end else if (m_owner >= 0) begin
      if (req[m_owner] && m_held < MAX_HOLD) begin
        m_held++;
      end else begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_dead  = TURNAROUND;
      end
    end else if (m_dead > 1) begin
      m_dead--;
    end else begin
      m_dead = 0;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (m_owner < 0 && req[j]) begin
          m_owner = j;
          m_held  = 1;
        end
      end
    end
  endtask

  task automatic compare_model();
    logic [N-1:0] eg;
    logic [W-1:0] ea;
    eg = '0;
    ea = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ea = data[m_owner*W +: W];
    end
    check("model_grant", grant, eg);
    check("model_bus_en", bus_en, (m_owner >= 0));
    check("model_bus_a", bus_a, ea);
    check("inv_onehot0", $onehot0(grant), 1);
    check("inv_bus_en_or", bus_en, |grant);
    if (m_rst_at_edge) begin
      prev_g = '0; zero_run = 0; seen_owner = 1'b0;
    end else if (grant != '0) begin
      if (prev_g != '0) check("inv_no_switch", grant, prev_g);
      else if (seen_owner) check("inv_gap", (zero_run >= TURNAROUND), 1);
      prev_g = grant; zero_run = 0; seen_owner = 1'b1;
    end else begin
      prev_g = '0; zero_run++;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    data = 16'h7A53;  // slices: 0=3, 1=5, 2=A, 3=7

    // Reset with all requests held, first grant after reset.
    tbl[0]  = '{1'b1, 4'b1111, 4'b0000, 4'h0};
    tbl[1]  = '{1'b1, 4'b1111, 4'b0000, 4'h0};
    tbl[2]  = '{1'b0, 4'b1111, 4'b0001, 4'h3};
    tbl[3]  = '{1'b0, 4'b0000, 4'b0000, 4'h0};
    tbl[4]  = '{1'b0, 4'b0000, 4'b0000, 4'h0};
    // Single requester 2.
    tbl[5]  = '{1'b0, 4'b0100, 4'b0100, 4'hA};
    tbl[6]  = '{1'b0, 4'b0100, 4'b0100, 4'hA};
    tbl[7]  = '{1'b0, 4'b0000, 4'b0000, 4'h0};
    tbl[8]  = '{1'b0, 4'b0000, 4'b0000, 4'h0};
    // Simultaneous 0 and 2 from ptr=0.
    tbl[9]  = '{1'b1, 4'b0000, 4'b0000, 4'h0};
    tbl[10] = '{1'b0, 4'b0101, 4'b0001, 4'h3};
    tbl[11] = '{1'b0, 4'b0100, 4'b0000, 4'h0};
    tbl[12] = '{1'b0, 4'b0100, 4'b0100, 4'hA};
    tbl[13] = '{1'b0, 4'b0000, 4'b0000, 4'h0};
    tbl[14] = '{1'b0, 4'b0000, 4'b0000, 4'h0};
    // Hold limit with 1 and 3 both requesting.
    tbl[15] = '{1'b1, 4'b0000, 4'b0000, 4'h0};
    tbl[16] = '{1'b0, 4'b1010, 4'b0010, 4'h5};
    tbl[17] = '{1'b0, 4'b1010, 4'b0010, 4'h5};
    tbl[18] = '{1'b0, 4'b1010, 4'b0010, 4'h5};
    tbl[19] = '{1'b0, 4'b1010, 4'b0010, 4'h5};
    tbl[20] = '{1'b0, 4'b1010, 4'b0000, 4'h0};
    tbl[21] = '{1'b0, 4'b1010, 4'b1000, 4'h7};
    tbl[22] = '{1'b0, 4'b1010, 4'b1000, 4'h7};
    tbl[23] = '{1'b0, 4'b1010, 4'b1000, 4'h7};
    tbl[24] = '{1'b0, 4'b1010, 4'b1000, 4'h7};
    tbl[25] = '{1'b0, 4'b1010, 4'b0000, 4'h0};
    tbl[26] = '{1'b0, 4'b1010, 4'b0010, 4'h5};
    // Reach owner 2 with ptr=2, then reset mid-OWN; arbitration restarts from ptr=0.
    tbl[27] = '{1'b0, 4'b0100, 4'b0000, 4'h0};
    tbl[28] = '{1'b0, 4'b0100, 4'b0100, 4'hA};
    tbl[29] = '{1'b1, 4'b0101, 4'b0000, 4'h0};
    tbl[30] = '{1'b0, 4'b0101, 4'b0001, 4'h3};
    tbl[31] = '{1'b0, 4'b0000, 4'b0000, 4'h0};
    tbl[32] = '{1'b0, 4'b0000, 4'b0000, 4'h0};

    for (int i = 0; i < NVEC; i++) begin
      rst = tbl[i].rst;
      req = tbl[i].req;
      cyc();
      check($sformatf("vec%0d_grant", i), grant, tbl[i].g);
      check($sformatf("vec%0d_bus_en", i), bus_en, |tbl[i].g);
      check($sformatf("vec%0d_bus_a", i), bus_a, tbl[i].a);
    end

    // Data tracking: owner data passes through same cycle, others ignored, dead/idle forces 0.
    rst = 1'b1; req = '0; data = 16'h7A53;
    cyc();
    rst = 1'b0; req = 4'b0010;
    cyc();
    check("dt_grant", grant, 4'b0010);
    check("dt_bus_a_init", bus_a, 4'h5);
    data[7:4] = 4'hC;
    #1;
    check("dt_owner_change", bus_a, 4'hC);
    data[15:12] = 4'hF;
    #1;
    check("dt_nonowner_change", bus_a, 4'hC);
    req = '0;
    cyc();
    check("dt_turn_bus_en", bus_en, 1'b0);
    check("dt_turn_bus_a", bus_a, 4'h0);
    data = 16'hFFFF;
    #1;
    check("dt_turn_data_change", bus_a, 4'h0);
    cyc();
    check("dt_idle_bus_a", bus_a, 4'h0);

    // Randomized traffic with sticky requests and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
      data = $urandom;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
